dram_line_master: RTL
=====================

# dram_line_master

Line-granular AXI4 master that converts single cache-line read/write requests into fixed-length INCR bursts on the 128-bit, 28-bit-address AXI slave port of the DDR3 controller wrapper. It sits directly upstream of the controller wrapper, in the `clk` domain, and is gated by its `locked` output. Each request produces exactly one response, including on error or abort.

## Interface
- `BEATS`, 4: beats per line (power of two, 2..16); line width is `BEATS*128` bits.
- `AXI_ID`, 4'h0: constant transaction ID driven on `awid` and `arid`.
- `clk` in 1: sole clock, shared with the controller wrapper's AXI slave side.
- `nrst` in 1: asynchronous, active-low reset.
- `locked` in 1: controller ready; requests are accepted only while high.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write line, 0 = read line.
- `req_addr` in 28: byte address; low `log2(BEATS*16)` bits are ignored (line-aligned).
- `req_wdata` in `BEATS*128`: write line; beat 0 = bits [127:0].
- `resp_valid` out 1 / `resp_ready` in 1: response handshake.
- `resp_rdata` out `BEATS*128`: read line, valid with a read response; otherwise 0.
- `resp_err` out 1: set on SLVERR/DECERR, an `rlast` mismatch, or an abort.
- `m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}` out 4/28/8/3/2/1/4/3/4/1, `m_axi_awready` in 1.
- `m_axi_w{data,strb,last,valid}` out 128/16/1/1, `m_axi_wready` in 1.
- `m_axi_b{id,resp,valid}` in 4/2/1, `m_axi_bready` out 1.
- `m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}` out (as AW), `m_axi_arready` in 1.
- `m_axi_r{id,data,resp,last,valid}` in 4/128/2/1/1, `m_axi_rready` out 1.

## Operation
- States: IDLE, AW, W, B, AR, R, RSP.
- IDLE: `req_ready = locked`. On handshake, register the line-aligned address and the write line.
  - Write goes to AW; read goes to AR.
- Constant AXI fields:
  - len = BEATS-1, size = 3'b100, burst = INCR.
  - lock, cache, prot and qos = 0; strb = all ones.
- AW: hold `awvalid` and stable fields until `awready`, then go to W.
- W: present beat k, with `wlast` on k = BEATS-1. Advance only on `wvalid & wready`. After the last beat, go to B.
- B: `bready` = 1. On `bvalid`, `err |= (bresp != 0)`, then go to RSP.
- AR: hold `arvalid` until `arready`, then go to R.
- R: `rready` = 1. Each accepted beat k is stored into `rdata[k*128 +: 128]`.
  - `err |= (rresp != 0)`.
  - `err |= (rlast != (k == BEATS-1))`.
  - After BEATS beats, go to RSP. Beats are always counted, never cut short by `rlast`.
- RSP: `resp_valid` = 1 until `resp_ready`, then go to IDLE and clear `err` and the beat counter.
- `locked` falling in AW, W, B, AR or R aborts:
  - Drop all AXI valids/readies next cycle.
  - Go to RSP with `resp_err` = 1 and `resp_rdata` = 0.
- `locked` falling in RSP has no effect.
- `bid` and `rid` are ignored; there is one outstanding transaction at a time.

## Timing
- All outputs are registered.
- Reset values: every valid/ready/last = 0, `resp_err` = 0, data/address = 0, state IDLE. Constant fields are driven at their constant values.
- `req_ready` is combinational from state and `locked` only.
- Request accepted at cycle 0 → `awvalid`/`arvalid` high at cycle 1.
- After the AW handshake at cycle n → `wvalid` high at n+1. With `wready` held high, beats are back-to-back: `wlast` at n+BEATS.
- B or final R handshake at cycle m → `resp_valid` high at m+1.
- Minimum write latency with all slave readies high: req to `resp_valid` = BEATS+3 cycles.
- Read latency = 2 + slave latency + BEATS.
- Asserting `nrst` mid-burst returns to reset values immediately (asynchronous). No response is issued for the aborted request.

## Structure
- Package `dram_line_pkg`:
  - state enum;
  - AXI constants: BURST_INCR, SIZE_16B, RESP_OKAY;
  - `LINE_OFS_W` function of BEATS.
- No sub-module; the beat counter and line shift/insert logic stay inline.

## Test plan
- Write: BEATS = 4, addr 0x0001234, data beats 0xA0..0xA3, slave always ready → awaddr 0x0001200, awlen 3, 4 beats with `wlast` on beat 3, response with err = 0 at cycle 7.
- Read: addr 0x0000040, slave returns 4 beats after 5 cycles → `resp_rdata` beats in order, err = 0.
- Backpressure: random `awready`/`wready`/`arready`, `resp_ready` low for 10 cycles → no beat lost or duplicated, fields stable while valid is high.
- Errors:
  - `bresp` = 2 → err = 1.
  - Read with `rlast` on beat 1 → still 4 beats consumed, err = 1.
- `locked` low in IDLE → `req_ready` = 0. `locked` dropped during W beat 2 → valids low next cycle, single response with err = 1.
- `nrst` asserted during R → all outputs at reset values within the same cycle. Next request completes normally.

Source files
------------

// File: rtl/dram_line_pkg.sv
// Shared types and AXI constants for the line-granular DDR3 AXI master.
package dram_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_RSP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_16B   = 3'b100;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Number of byte-address bits covered by one cache line.
    function automatic int unsigned line_ofs_w(input int unsigned beats);
        return $clog2(beats * 16);
    endfunction

endpackage

// File: rtl/dram_line_master_if.sv
// AXI4 bus between the line master and the DDR3 controller wrapper (128-bit data, 28-bit address).
interface dram_line_master_if;

    logic [3:0]   m_axi_awid;
    logic [27:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awlock;
    logic [3:0]   m_axi_awcache;
    logic [2:0]   m_axi_awprot;
    logic [3:0]   m_axi_awqos;
    logic         m_axi_awvalid;
    logic         m_axi_awready;

    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;

    logic [3:0]   m_axi_bid;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;

    logic [3:0]   m_axi_arid;
    logic [27:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic [3:0]   m_axi_arqos;
    logic         m_axi_arvalid;
    logic         m_axi_arready;

    logic [3:0]   m_axi_rid;
    logic [127:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/dram_line_master.sv
// Converts single cache-line read/write requests into one fixed-length INCR AXI4 burst each,
// producing exactly one response per request (including on bus error or loss of `locked`).
module dram_line_master
    import dram_line_pkg::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter logic [3:0]  AXI_ID = 4'h0
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   locked,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [27:0]            req_addr,
    input  logic [BEATS*128-1:0]   req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [BEATS*128-1:0]   resp_rdata,
    output logic                   resp_err,
    dram_line_master_if.master     m_axi
);

    localparam int unsigned LINE_W     = BEATS * 128;
    localparam int unsigned LINE_OFS_W = line_ofs_w(BEATS);
    localparam int unsigned BW         = $clog2(BEATS);
    localparam logic [27:0] ADDR_MASK  = ~((28'd1 << LINE_OFS_W) - 28'd1);
    localparam logic [BW-1:0] LAST_BEAT   = BW'(BEATS - 1);
    localparam logic [BW-1:0] PENULT_BEAT = BW'(BEATS - 2);

    state_t              state;
    logic [BW-1:0]       beat;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_ins;
    logic [27:0]         addr_aligned;
    logic                unused_ids;

    assign unused_ids   = ^{m_axi.m_axi_bid, m_axi.m_axi_rid};
    assign addr_aligned = req_addr & ADDR_MASK;
    assign req_ready    = (state == ST_IDLE) && locked;

    assign m_axi.m_axi_awid    = AXI_ID;
    assign m_axi.m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi.m_axi_awsize  = SIZE_16B;
    assign m_axi.m_axi_awburst = BURST_INCR;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = '0;
    assign m_axi.m_axi_awprot  = '0;
    assign m_axi.m_axi_awqos   = '0;
    assign m_axi.m_axi_wstrb   = '1;
    assign m_axi.m_axi_arid    = AXI_ID;
    assign m_axi.m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi.m_axi_arsize  = SIZE_16B;
    assign m_axi.m_axi_arburst = BURST_INCR;
    assign m_axi.m_axi_arlock  = 1'b0;
    assign m_axi.m_axi_arcache = '0;
    assign m_axi.m_axi_arprot  = '0;
    assign m_axi.m_axi_arqos   = '0;

    // Read line with the current R beat dropped into its slot.
    always_comb begin
        line_ins = line_q;
        line_ins[{beat, 7'b0} +: 128] = m_axi.m_axi_rdata;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                <= ST_IDLE;
            beat                 <= '0;
            line_q               <= '0;
            resp_valid           <= 1'b0;
            resp_rdata           <= '0;
            resp_err             <= 1'b0;
            m_axi.m_axi_awaddr   <= '0;
            m_axi.m_axi_awvalid  <= 1'b0;
            m_axi.m_axi_wdata    <= '0;
            m_axi.m_axi_wlast    <= 1'b0;
            m_axi.m_axi_wvalid   <= 1'b0;
            m_axi.m_axi_bready   <= 1'b0;
            m_axi.m_axi_araddr   <= '0;
            m_axi.m_axi_arvalid  <= 1'b0;
            m_axi.m_axi_rready   <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (req_valid && locked) begin
                if (req_write) begin
                    m_axi.m_axi_awaddr  <= addr_aligned;
                    m_axi.m_axi_awvalid <= 1'b1;
                    line_q              <= req_wdata;
                    state               <= ST_AW;
                end else begin
                    m_axi.m_axi_araddr  <= addr_aligned;
                    m_axi.m_axi_arvalid <= 1'b1;
                    line_q              <= '0;
                    state               <= ST_AR;
                end
            end
        end else if (state == ST_RSP) begin
            if (resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
                resp_rdata <= '0;
                beat       <= '0;
                state      <= ST_IDLE;
            end
        end else if (!locked) begin
            // Abort: any in-flight handshake on this edge is deliberately ignored.
            m_axi.m_axi_awvalid <= 1'b0;
            m_axi.m_axi_wvalid  <= 1'b0;
            m_axi.m_axi_wlast   <= 1'b0;
            m_axi.m_axi_wdata   <= '0;
            m_axi.m_axi_bready  <= 1'b0;
            m_axi.m_axi_arvalid <= 1'b0;
            m_axi.m_axi_rready  <= 1'b0;
            line_q              <= '0;
            resp_rdata          <= '0;
            resp_err            <= 1'b1;
            resp_valid          <= 1'b1;
            state               <= ST_RSP;
        end else begin
            case (state)
                ST_AW: if (m_axi.m_axi_awready) begin
                    m_axi.m_axi_awvalid <= 1'b0;
                    m_axi.m_axi_wvalid  <= 1'b1;
                    m_axi.m_axi_wdata   <= line_q[127:0];
                    m_axi.m_axi_wlast   <= 1'b0;
                    line_q              <= line_q >> 128;
                    state               <= ST_W;
                end
                ST_W: if (m_axi.m_axi_wready) begin
                    if (m_axi.m_axi_wlast) begin
                        m_axi.m_axi_wvalid <= 1'b0;
                        m_axi.m_axi_wlast  <= 1'b0;
                        m_axi.m_axi_wdata  <= '0;
                        m_axi.m_axi_bready <= 1'b1;
                        state              <= ST_B;
                    end else begin
                        m_axi.m_axi_wdata <= line_q[127:0];
                        m_axi.m_axi_wlast <= (beat == PENULT_BEAT);
                        line_q            <= line_q >> 128;
                        beat              <= beat + 1'b1;
                    end
                end
                ST_B: if (m_axi.m_axi_bvalid) begin
                    m_axi.m_axi_bready <= 1'b0;
                    if (m_axi.m_axi_bresp != RESP_OKAY) resp_err <= 1'b1;
                    resp_valid         <= 1'b1;
                    state              <= ST_RSP;
                end
                ST_AR: if (m_axi.m_axi_arready) begin
                    m_axi.m_axi_arvalid <= 1'b0;
                    m_axi.m_axi_rready  <= 1'b1;
                    state               <= ST_R;
                end
                ST_R: if (m_axi.m_axi_rvalid) begin
                    if ((m_axi.m_axi_rresp != RESP_OKAY) ||
                        (m_axi.m_axi_rlast != (beat == LAST_BEAT)))
                        resp_err <= 1'b1;
                    line_q <= line_ins;
                    beat   <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        m_axi.m_axi_rready <= 1'b0;
                        resp_rdata         <= line_ins;
                        resp_valid         <= 1'b1;
                        state              <= ST_RSP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
